// File: rtl/packed_product_accumulator.sv
// Splits packed product words into signed lanes and accumulates each lane over a
// group of beats closed by in_last; the lane sums are offered on a valid/ready port.
module packed_product_accumulator #(
  parameter int ACC_W = 24,
  parameter int SAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_p,
  input  logic                 in_mode,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*ACC_W-1:0]   out_acc,
  output logic                 out_mode,
  output logic [CNT_W-1:0]     out_count,
  output logic [3:0]           out_sat,
  output logic                 err_mode
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_OUT
  } state_t;

  state_t                   state_q, state_d;
  logic [3:0][ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     mode_q, mode_d;
  logic [3:0]               sat_q, sat_d;
  logic                     err_q, err_d;

  logic                     beat_acc;
  logic                     eff_mode;
  logic [3:0][ACC_W-1:0]    sum_val;
  logic [3:0]               lane_clamp;

  assign in_ready = (state_q != S_OUT);
  assign beat_acc = in_valid && in_ready;
  // Mid-group beats are always decoded with the mode latched on the first beat.
  assign eff_mode = (state_q == S_ACC) ? mode_q : in_mode;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [15:0]    lane_w;
    logic [ACC_W:0] base_ext;
    logic [ACC_W:0] lane_ext;
    logic [ACC_W:0] raw_sum;
    logic           ovf;

    if (gi < 2) begin : g_lo
      assign lane_w = eff_mode ? {{8{in_p[8*gi+7]}}, in_p[8*gi +: 8]} : in_p[16*gi +: 16];
    end else begin : g_hi
      assign lane_w = eff_mode ? {{8{in_p[8*gi+7]}}, in_p[8*gi +: 8]} : 16'h0000;
    end

    // The first beat of a group loads rather than adds, so the base is zero outside ACC.
    assign base_ext = (state_q == S_ACC) ? {acc_q[gi][ACC_W-1], acc_q[gi]} : '0;
    assign lane_ext = {{(ACC_W-15){lane_w[15]}}, lane_w};
    assign raw_sum  = base_ext + lane_ext;
    assign ovf      = raw_sum[ACC_W] ^ raw_sum[ACC_W-1];

    if (SAT != 0) begin : g_sat
      assign sum_val[gi] = !ovf ? raw_sum[ACC_W-1:0]
                         : (raw_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}});
      assign lane_clamp[gi] = ovf;
    end else begin : g_wrap
      assign sum_val[gi]    = raw_sum[ACC_W-1:0];
      assign lane_clamp[gi] = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    mode_d  = mode_q;
    sat_d   = sat_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (beat_acc) begin
          acc_d   = sum_val;
          mode_d  = in_mode;
          count_d = CNT_W'(1);
          sat_d   = lane_clamp;
          state_d = in_last ? S_OUT : S_ACC;
        end
      end
      S_ACC: begin
        if (beat_acc) begin
          acc_d   = sum_val;
          sat_d   = sat_q | lane_clamp;
          count_d = (&count_q) ? count_q : count_q + 1'b1;
          err_d   = (in_mode != mode_q);
          if (in_last) begin
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
          acc_d   = '0;
          count_d = '0;
          mode_d  = 1'b0;
          sat_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      sat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  // The accumulator registers double as the held output registers while in OUT.
  assign out_valid = (state_q == S_OUT);
  assign out_acc   = acc_q;
  assign out_mode  = mode_q;
  assign out_count = count_q;
  assign out_sat   = sat_q;
  assign err_mode  = err_q;

endmodule
